// File: rtl/sd_save_sched_pkg.sv
// Shared widths and a sizing helper for the SD image-save sequencer.
package sd_save_sched_pkg;

    localparam int ADDR_W = 32;
    localparam int SLOT_W = 3;

    // Bits needed to hold every value from 0 up to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sd_save_sched_if.sv
// Handshake between the save sequencer, the write FIFO fill level and the SPI sector-write engine.
interface sd_save_sched_if #(
    parameter int FIFO_LEN_W = 10
) ();
    import sd_save_sched_pkg::*;

    logic [FIFO_LEN_W-1:0] fifo_len;
    logic                  fifo_rd_en;
    logic                  wr_start_en;
    logic [ADDR_W-1:0]     wr_sec_addr;
    logic                  wr_busy;
    logic                  wr_req;

    modport master (
        input  fifo_len,
        input  wr_busy,
        input  wr_req,
        output fifo_rd_en,
        output wr_start_en,
        output wr_sec_addr
    );

    modport slave (
        output fifo_len,
        output wr_busy,
        output wr_req,
        input  fifo_rd_en,
        input  wr_start_en,
        input  wr_sec_addr
    );

endinterface

// File: rtl/sd_save_sched_sec_timer.sv
// Per-sector watchdog: loaded at sector launch, counts down while enabled, flags expiry.
module sd_sec_timer
    import sd_save_sched_pkg::*;
#(
    parameter int TIMEOUT = 2_400_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = cnt_width(TIMEOUT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Loaded with TIMEOUT-1 so expiry fires on the TIMEOUT-th enabled cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(TIMEOUT - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/sd_save_sched.sv
// Sequences one image save into consecutive SD sectors: waits for a sector of buffered
// data, launches the sector write, gates FIFO reads, and rotates images through card slots.
module sd_save_sched
    import sd_save_sched_pkg::*;
#(
    parameter int START_SECTOR      = 16640,
    parameter int SECTORS_PER_IMAGE = 1200,
    parameter int IMAGE_SLOTS       = 8,
    parameter int SECTOR_WORDS      = 256,
    parameter int FIFO_LEN_W        = 10,
    parameter int TIMEOUT           = 2_400_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              sd_init_done,
    input  logic              save_req,
    sd_save_sched_if.master   eng,
    output logic              busy,
    output logic              image_done,
    output logic [SLOT_W-1:0] slot_idx,
    output logic              err
);

    localparam int SEC_W  = cnt_width(SECTORS_PER_IMAGE - 1);
    localparam int WORD_W = cnt_width(SECTOR_WORDS);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_WAIT_DATA    = 3'd1;
    localparam logic [2:0] S_ISSUE        = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY_HI = 3'd3;
    localparam logic [2:0] S_XFER         = 3'd4;
    localparam logic [2:0] S_NEXT         = 3'd5;
    localparam logic [2:0] S_DONE         = 3'd6;
    localparam logic [2:0] S_ERR          = 3'd7;

    localparam logic [FIFO_LEN_W:0] SEC_WORDS_F = (FIFO_LEN_W + 1)'(SECTOR_WORDS);
    localparam logic [ADDR_W-1:0]   BASE_START  = ADDR_W'(START_SECTOR);
    localparam logic [ADDR_W-1:0]   BASE_STEP   = ADDR_W'(SECTORS_PER_IMAGE);

    logic [2:0]            state_q,     state_d;
    logic                  save_dly_q,  save_dly_d;
    logic                  save_pls_q,  save_pls_d;
    logic [SEC_W-1:0]      sec_cnt_q,   sec_cnt_d;
    logic [WORD_W-1:0]     word_cnt_q,  word_cnt_d;
    logic [ADDR_W-1:0]     slot_base_q, slot_base_d;
    logic [SLOT_W-1:0]     slot_idx_q,  slot_idx_d;
    logic [ADDR_W-1:0]     sec_addr_q,  sec_addr_d;
    logic                  busy_q,      busy_d;
    logic                  err_q,       err_d;

    logic [FIFO_LEN_W-1:0] fifo_len_w;
    logic                  data_ready;
    logic                  rd_en;
    logic                  abort;
    logic                  tmr_load;
    logic                  tmr_en;
    logic                  tmr_expired;

    assign fifo_len_w = eng.fifo_len;
    assign data_ready = {1'b0, fifo_len_w} >= SEC_WORDS_F;

    // Reads stop at a full sector; surplus engine requests are simply not serviced.
    assign rd_en = (state_q == S_XFER) && eng.wr_req &&
                   (word_cnt_q < WORD_W'(SECTOR_WORDS));

    assign abort = !sd_init_done &&
                   (state_q inside {S_WAIT_DATA, S_ISSUE, S_WAIT_BUSY_HI, S_XFER, S_NEXT});

    assign tmr_load = (state_q == S_ISSUE);
    assign tmr_en   = (state_q == S_WAIT_BUSY_HI) || (state_q == S_XFER);

    sd_sec_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_sec_timer (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .load    (tmr_load),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        save_dly_d  = save_req;
        save_pls_d  = save_req && !save_dly_q;
        sec_cnt_d   = sec_cnt_q;
        word_cnt_d  = word_cnt_q;
        slot_base_d = slot_base_q;
        slot_idx_d  = slot_idx_q;
        sec_addr_d  = sec_addr_q;
        busy_d      = busy_q;
        err_d       = err_q;

        if (rd_en) begin
            word_cnt_d = word_cnt_q + WORD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (save_pls_q && sd_init_done) begin
                    state_d   = S_WAIT_DATA;
                    sec_cnt_d = '0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_WAIT_DATA: begin
                // Address is captured here so it is already valid alongside the start pulse.
                if (data_ready) begin
                    state_d    = S_ISSUE;
                    sec_addr_d = slot_base_q + ADDR_W'(sec_cnt_q);
                end
            end
            S_ISSUE: begin
                word_cnt_d = '0;
                state_d    = S_WAIT_BUSY_HI;
            end
            S_WAIT_BUSY_HI: begin
                if (eng.wr_busy) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (!eng.wr_busy) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (sec_cnt_q == SEC_W'(SECTORS_PER_IMAGE - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    if (slot_idx_q == SLOT_W'(IMAGE_SLOTS - 1)) begin
                        slot_idx_d  = '0;
                        slot_base_d = BASE_START;
                    end else begin
                        slot_idx_d  = slot_idx_q + SLOT_W'(1);
                        slot_base_d = slot_base_q + BASE_STEP;
                    end
                end else begin
                    sec_cnt_d = sec_cnt_q + SEC_W'(1);
                    state_d   = S_WAIT_DATA;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Card loss or a stalled engine overrides any normal progression.
        if (abort || tmr_expired) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            save_dly_q  <= 1'b0;
            save_pls_q  <= 1'b0;
            sec_cnt_q   <= '0;
            word_cnt_q  <= '0;
            slot_base_q <= BASE_START;
            slot_idx_q  <= '0;
            sec_addr_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            save_dly_q  <= save_dly_d;
            save_pls_q  <= save_pls_d;
            sec_cnt_q   <= sec_cnt_d;
            word_cnt_q  <= word_cnt_d;
            slot_base_q <= slot_base_d;
            slot_idx_q  <= slot_idx_d;
            sec_addr_q  <= sec_addr_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign eng.fifo_rd_en  = rd_en;
    assign eng.wr_start_en = (state_q == S_ISSUE);
    assign eng.wr_sec_addr = sec_addr_q;
    assign busy            = busy_q;
    assign image_done      = (state_q == S_DONE);
    assign slot_idx        = slot_idx_q;
    assign err             = err_q;

endmodule

// File: tb/tb_sd_save_sched.sv
// Directed-plus-random bench for sd_save_sched: one sequencer driven by a randomised
// engine model, a second with a short timeout whose engine never responds.
module tb_sd_save_sched;

    localparam int START = 16640;
    localparam int SPI   = 3;
    localparam int SLOTS = 8;
    localparam int SW    = 256;
    localparam int TO_A  = 2000;
    localparam int TO_B  = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       init_done;
    logic       save_req;
    logic       save_req_b;
    logic [9:0] fifo_len;
    logic       eng_busy;
    logic       eng_req;

    logic       busy_a, done_a, err_a;
    logic [2:0] slot_a;
    logic       busy_b, done_b, err_b;
    logic [2:0] slot_b;

    sd_save_sched_if #(.FIFO_LEN_W(10)) ifa ();
    sd_save_sched_if #(.FIFO_LEN_W(10)) ifb ();

    assign ifa.fifo_len = fifo_len;
    assign ifa.wr_busy  = eng_busy;
    assign ifa.wr_req   = eng_req;
    assign ifb.fifo_len = fifo_len;
    assign ifb.wr_busy  = 1'b0;
    assign ifb.wr_req   = 1'b0;

    sd_save_sched #(
        .SECTORS_PER_IMAGE (SPI),
        .IMAGE_SLOTS       (SLOTS),
        .TIMEOUT           (TO_A)
    ) dut_a (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .sd_init_done (init_done),
        .save_req     (save_req),
        .eng          (ifa),
        .busy         (busy_a),
        .image_done   (done_a),
        .slot_idx     (slot_a),
        .err          (err_a)
    );

    sd_save_sched #(
        .SECTORS_PER_IMAGE (SPI),
        .IMAGE_SLOTS       (SLOTS),
        .TIMEOUT           (TO_B)
    ) dut_b (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .sd_init_done (init_done),
        .save_req     (save_req_b),
        .eng          (ifb),
        .busy         (busy_b),
        .image_done   (done_b),
        .slot_idx     (slot_b),
        .err          (err_b)
    );

    int checks   = 0;
    int failures = 0;
    int rd_total = 0;
    int slot_m   = 0;
    bit eng_act  = 1'b0;

    // Counts reads that the DUT will commit at the coming rising edge.
    always @(negedge clk) begin
        #1;
        if (ifa.fifo_rd_en === 1'b1) rd_total++;
    end

    // Engine model: busy two cycles after start, 256+extra randomly spaced requests, then idle.
    initial begin
        int n;
        int extra;
        eng_busy = 1'b0;
        eng_req  = 1'b0;
        forever begin
            @(negedge clk);
            if (ifa.wr_start_en === 1'b1) begin
                eng_act = 1'b1;
                extra   = int'($urandom_range(0, 3));
                repeat (2) @(negedge clk);
                eng_busy = 1'b1;
                n = 0;
                while (n < SW + extra) begin
                    @(negedge clk);
                    eng_req = ($urandom_range(0, 3) != 0);
                    if (eng_req) begin
                        n++;
                        if (n == SW + extra && extra == 0 && $urandom_range(0, 1) == 1)
                            eng_busy = 1'b0;
                    end
                end
                @(negedge clk);
                eng_req  = 1'b0;
                eng_busy = 1'b0;
                eng_act  = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_save();
        save_req = 1'b1;
        tick(2);
        save_req = 1'b0;
    endtask

    task automatic wait_eng_idle();
        int c = 0;
        while (eng_act && c < 3000) begin
            @(negedge clk);
            c++;
        end
        tick(2);
        chk("engine_idle", 32'(eng_act), 0);
    endtask

    task automatic wait_start(input string tag, output bit ok);
        int c = 0;
        ok = 1'b0;
        while (c < 3000) begin
            @(negedge clk);
            if (ifa.wr_start_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
            c++;
        end
        chk(tag, 32'(ok), 1);
    endtask

    task automatic do_save(input bit hold255, input bit mid_pulse, input bit rst_mid);
        int  base = 0;
        bit  ok;
        bit  seen;
        int  c;
        wait_eng_idle();
        fifo_len = hold255 ? 10'd255 : 10'($urandom_range(256, 700));
        pulse_save();
        chk("busy_set", 32'(busy_a), 1);
        chk("err_clr", 32'(err_a), 0);
        chk("slot_at_start", 32'(slot_a), 32'(slot_m));
        for (int s = 0; s < SPI; s++) begin
            if (s == 0 && hold255) begin
                seen = 1'b0;
                for (int k = 0; k < 1000; k++) begin
                    @(negedge clk);
                    if (ifa.wr_start_en === 1'b1) seen = 1'b1;
                end
                chk("hold255_no_start", 32'(seen), 0);
                chk("hold255_err", 32'(err_a), 0);
                fifo_len = 10'd256;
                @(negedge clk);
                ok = (ifa.wr_start_en === 1'b1);
                chk("start_after_256", 32'(ok), 1);
            end else begin
                wait_start("start_seen", ok);
            end
            if (!ok) return;
            if (s > 0) chk("rd_per_sector", 32'(rd_total - base), SW);
            base = rd_total;
            chk("sec_addr", ifa.wr_sec_addr, 32'(START + slot_m * SPI + s));
            if (s == 1 && mid_pulse) pulse_save();
            if (s == 1 && rst_mid) begin
                tick(20);
                rst_n = 1'b0;
                #1;
                chk("rst_busy", 32'(busy_a), 0);
                chk("rst_err", 32'(err_a), 0);
                chk("rst_slot", 32'(slot_a), 0);
                chk("rst_done", 32'(done_a), 0);
                chk("rst_start", 32'(ifa.wr_start_en), 0);
                chk("rst_rd_en", 32'(ifa.fifo_rd_en), 0);
                chk("rst_addr", ifa.wr_sec_addr, 0);
                tick(2);
                rst_n  = 1'b1;
                slot_m = 0;
                return;
            end
        end
        c  = 0;
        ok = 1'b0;
        while (c < 3000) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                ok = 1'b1;
                break;
            end
            c++;
        end
        chk("image_done_seen", 32'(ok), 1);
        chk("rd_last_sector", 32'(rd_total - base), SW);
        slot_m = (slot_m + 1) % SLOTS;
        chk("slot_at_done", 32'(slot_a), 32'(slot_m));
        chk("busy_at_done", 32'(busy_a), 0);
        chk("err_at_done", 32'(err_a), 0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_a), 0);
    endtask

    initial begin
        bit ok;
        bit seen;
        int base;
        int c;

        rst_n      = 1'b0;
        init_done  = 1'b1;
        save_req   = 1'b0;
        save_req_b = 1'b0;
        fifo_len   = 10'd0;
        tick(3);
        chk("reset_busy", 32'(busy_a), 0);
        chk("reset_done", 32'(done_a), 0);
        chk("reset_err", 32'(err_a), 0);
        chk("reset_slot", 32'(slot_a), 0);
        chk("reset_start", 32'(ifa.wr_start_en), 0);
        chk("reset_rd_en", 32'(ifa.fifo_rd_en), 0);
        chk("reset_addr", ifa.wr_sec_addr, 0);
        rst_n = 1'b1;
        tick(2);

        do_save(1'b0, 1'b0, 1'b0);
        do_save(1'b1, 1'b0, 1'b0);
        do_save(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) do_save(1'b0, 1'b0, 1'b0);
        chk("wrapped_slot", 32'(slot_a), 0);
        do_save(1'b0, 1'b0, 1'b0);

        // Card removal mid-transfer.
        wait_eng_idle();
        fifo_len = 10'd300;
        pulse_save();
        wait_start("abort_start_seen", ok);
        base = rd_total;
        c = 0;
        while ((rd_total - base) < 50 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        init_done = 1'b0;
        @(negedge clk);
        chk("abort_err", 32'(err_a), 1);
        chk("abort_busy", 32'(busy_a), 0);
        tick(2);
        seen = 1'b0;
        save_req = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 2) save_req = 1'b0;
            if (ifa.wr_start_en === 1'b1 || busy_a === 1'b1) seen = 1'b1;
        end
        chk("no_init_ignored", 32'(seen), 0);
        chk("err_sticky", 32'(err_a), 1);
        chk("slot_kept_after_abort", 32'(slot_a), 32'(slot_m));
        init_done = 1'b1;
        tick(2);

        do_save(1'b0, 1'b0, 1'b0);
        do_save(1'b0, 1'b0, 1'b1);
        do_save(1'b0, 1'b0, 1'b0);

        // Engine that never answers: watchdog on the short-timeout instance.
        for (int k = 0; k < 2; k++) begin
            fifo_len   = 10'd300;
            save_req_b = 1'b1;
            tick(2);
            save_req_b = 1'b0;
            chk("to_err_clr", 32'(err_b), 0);
            c  = 0;
            ok = 1'b0;
            while (c < 100) begin
                @(negedge clk);
                if (ifb.wr_start_en === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                c++;
            end
            chk("to_start_seen", 32'(ok), 1);
            chk("to_addr", ifb.wr_sec_addr, START);
            chk("to_slot", 32'(slot_b), 0);
            c    = 0;
            seen = 1'b0;
            while (err_b !== 1'b1 && c < 500) begin
                @(negedge clk);
                c++;
                if (done_b === 1'b1) seen = 1'b1;
            end
            chk("to_latency_min", 32'(c >= TO_B), 1);
            chk("to_latency_max", 32'(c <= TO_B + 2), 1);
            chk("to_busy", 32'(busy_b), 0);
            chk("to_no_done", 32'(seen), 0);
            tick(3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_save_sched.md
Name: sd_save_sched

Overview:
Sequences one CMOS image save into consecutive SD-card sectors. It sits between the debounced save key, the 32w/16r write FIFO fill level and the SPI sector-write engine inside the SD top. Per sector it waits for one sector of buffered data, then issues a start pulse with the sector address and gates FIFO reads to the engine's data requests. It also rotates images through a ring of fixed-size card slots and flags timeouts.

Parameters:
START_SECTOR, 16640, first card sector of slot 0
SECTORS_PER_IMAGE, 1200, sectors per image (640x480x16 bit / 512 B)
IMAGE_SLOTS, 8, number of image slots in the ring
SECTOR_WORDS, 256, 16-bit words per 512 B sector
FIFO_LEN_W, 10, width of fifo_len
TIMEOUT, 2_400_000, max cycles spent on one sector (0.1 s at 24 MHz)

Ports:
sys_clk  in  1  single clock (SD reference clock domain)
sys_rst_n  in  1  asynchronous active-low reset
sd_init_done  in  1  card initialised, level
save_req  in  1  debounced save request, level; rising edge triggers
fifo_len  in  FIFO_LEN_W  16-bit words available in write FIFO
fifo_rd_en  out  1  FIFO read strobe
wr_start_en  out  1  one-cycle sector-write start pulse
wr_sec_addr  out  32  sector address, valid from wr_start_en until the sector completes
wr_busy  in  1  write engine busy, level
wr_req  in  1  write engine requests the next data word
busy  out  1  image save in progress
image_done  out  1  one-cycle pulse after the last sector
slot_idx  out  3  slot currently or last written
err  out  1  sticky timeout/abort flag

Behaviour:
- Reset values: all outputs 0. State IDLE. Sector counter 0. Slot 0. Slot base = START_SECTOR.
- A registered rising-edge detect on save_req produces save_pls.
- IDLE: save_pls && sd_init_done -> WAIT_DATA. This clears err and the sector counter, and sets busy=1. save_pls is ignored in any state other than IDLE, and is ignored when sd_init_done=0.
- WAIT_DATA: fifo_len >= SECTOR_WORDS -> ISSUE.
- ISSUE: wr_start_en=1 for exactly 1 cycle. wr_sec_addr is registered as slot_base + sec_cnt. Then -> WAIT_BUSY_HI.
- WAIT_BUSY_HI: wr_busy=1 -> XFER.
- XFER:
  - fifo_rd_en = wr_req && (word_cnt < SECTOR_WORDS), combinational, so zero-latency FIFO read.
  - word_cnt increments on each fifo_rd_en and is cleared in ISSUE.
  - wr_busy=0 -> NEXT.
- NEXT:
  - If sec_cnt == SECTORS_PER_IMAGE-1, -> DONE.
  - Otherwise sec_cnt+1 and -> WAIT_DATA.
- DONE:
  - image_done=1 for 1 cycle and busy=0.
  - Slot advance: slot_base += SECTORS_PER_IMAGE and slot_idx += 1.
  - Ring wrap: when slot_idx == IMAGE_SLOTS-1 the slot wraps to slot_idx=0, slot_base=START_SECTOR.
  - Slot arithmetic is accumulator only, with no multiplier.
  - -> IDLE.
- Timeout:
  - A per-sector cycle counter clears in ISSUE and runs during WAIT_BUSY_HI and XFER.
  - On reaching TIMEOUT: -> ERR. WAIT_DATA has no timeout (the source may be slow).
- Abort: sd_init_done=0 in any non-IDLE state -> ERR.
- ERR: err=1 (sticky) and busy=0. No image_done pulse, and the slot is not advanced. -> IDLE on the next cycle.
- Simultaneous wr_req with the wr_busy fall in XFER: the read is honoured (counted), then -> NEXT.
- Extra wr_req beyond SECTOR_WORDS: no fifo_rd_en. This is not an error.
- Asynchronous reset mid-save clears everything immediately, including the slot position.

Decomposition:
- No shared package needed. State encoding is a localparam in the module.
- Natural sub-module: sd_sec_timer, the loadable per-sector timeout counter with a clear and an expiry flag.
- Edge detect stays inline.

Test Plan:
- Set SECTORS_PER_IMAGE=3. Pulse save_req with sd_init_done=1 and fifo_len=300. The engine model raises wr_busy 2 cycles after start, issues 256 wr_req, then drops busy. Expect 3 wr_start_en with wr_sec_addr 16640, 16641, 16642. Expect 256 fifo_rd_en per sector, then image_done with slot_idx=1.
- Hold fifo_len=255 for 1000 cycles, then set 256. Expect no wr_start_en until the cycle after fifo_len=256, and err stays 0.
- Run 8 back-to-back saves with IMAGE_SLOTS=8. On the 9th save, expect first wr_sec_addr = 16640 (wrap) and slot_idx=0 at the start.
- Set TIMEOUT=100 and make the engine never raise wr_busy. Expect err=1 at 100 cycles after ISSUE, busy=0, no image_done, and the next save reuses the same slot_base.
- Drop sd_init_done mid-XFER. Expect err=1, busy=0 and return to IDLE. Further save_req while sd_init_done=0 is ignored.
- Pulse save_req again while busy. Expect no restart and the sector sequence is unchanged. Separately, assert reset mid-sector: all outputs go to 0 immediately, and the next wr_sec_addr is 16640.
